// File: rtl/wts_pkg.sv
// Shared definitions for the wave-table channel mixer.
//   - FSM state encoding for the mix sequencer
//   - SRAM address / wave data widths and the term shift amount
//   - derived widths for the multiply, term and accumulator datapath
package wts_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } wts_state_e;

  localparam int unsigned SramAddrW = 10;  // {channel[2:0], wave_addr[6:0]}
  localparam int unsigned WaveW     = 8;   // two's complement wave sample
  localparam int unsigned TermShift = 4;   // product >>> TermShift gives the term

  localparam int unsigned EnvW      = 8;
  localparam int unsigned WaveAddrW = 7;
  localparam int unsigned ChIdxW    = SramAddrW - WaveAddrW;
  localparam int unsigned MaxCh     = 1 << ChIdxW;
  localparam int unsigned ProdW     = WaveW + EnvW + 1;     // signed x {0,unsigned}
  localparam int unsigned TermW     = ProdW - TermShift;
  localparam int unsigned AccW      = 16;

endpackage

// File: rtl/wts_mix_mac.sv
// Signed-by-unsigned multiply / shift / mask / accumulate for one mix pass.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   clear_i       clears the accumulator (start of a pass)
//   term_vld_i    wave_i/envelope_i/mask_i hold a term to add this cycle
//   wave_i        signed wave sample from SRAM
//   envelope_i    unsigned channel envelope
//   mask_i        0 forces the term to zero
//   acc_next_o    accumulator value after this cycle's update
module wts_mix_mac
  import wts_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   term_vld_i,
  input  logic [WaveW-1:0]       wave_i,
  input  logic [EnvW-1:0]        envelope_i,
  input  logic                   mask_i,
  output logic signed [AccW-1:0] acc_next_o
);

  logic signed [ProdW-1:0] wave_s;
  logic signed [ProdW-1:0] env_s;
  logic signed [ProdW-1:0] prod;
  logic signed [TermW-1:0] term;
  logic signed [AccW-1:0]  term_ext;
  logic signed [AccW-1:0]  acc_q, acc_d;

  // Both operands widened to the full product width so the low ProdW bits
  // of the multiply are exact.
  assign wave_s = {{(ProdW-WaveW){wave_i[WaveW-1]}}, wave_i};
  assign env_s  = {{(ProdW-EnvW){1'b0}}, envelope_i};
  assign prod   = wave_s * env_s;
  assign term   = TermW'(prod >>> TermShift);

  always_comb begin
    term_ext = '0;
    if (mask_i) begin
      term_ext = {{(AccW-TermW){term[TermW-1]}}, term};
    end
  end

  // Range of the terms guarantees the sum fits in AccW bits.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (term_vld_i) begin
      acc_d = acc_q + term_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/wts_channel_mixer.sv
// Wave-table channel mixer: on a start pulse, snapshots the channel envelopes,
// wave addresses and mask, reads one wave sample per channel from the wave
// SRAM, and sums envelope-scaled samples into a 16-bit signed output.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   start            one-cycle request for a mix pass (ignored while busy)
//   envelope_flat    channel n envelope at [8n+7:8n]
//   wave_addr_flat   channel n wave address at [7n+6:7n]
//   channel_mask     1 = channel contributes
//   sram_rd, sram_a  wave SRAM read strobe and address {channel, wave_addr}
//   sram_q           wave SRAM data, valid the cycle after sram_rd
//   busy             pass in progress
//   sample_out       mixed sample, held between passes
//   sample_valid     pulses with each new sample_out
//   overrun          pulses when a start is dropped because a pass is running
module wts_channel_mixer
  import wts_pkg::*;
#(
  parameter int unsigned NUM_CH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [EnvW*NUM_CH-1:0]      envelope_flat,
  input  logic [WaveAddrW*NUM_CH-1:0] wave_addr_flat,
  input  logic [NUM_CH-1:0]           channel_mask,
  output logic                        sram_rd,
  output logic [SramAddrW-1:0]        sram_a,
  input  logic [WaveW-1:0]            sram_q,
  output logic                        busy,
  output logic signed [AccW-1:0]      sample_out,
  output logic                        sample_valid,
  output logic                        overrun
);

  localparam int unsigned EnvFlatW  = EnvW * MaxCh;
  localparam int unsigned AddrFlatW = WaveAddrW * MaxCh;

  wts_state_e             state_q;
  logic [ChIdxW-1:0]      ch_q;
  logic [EnvFlatW-1:0]    env_q;
  logic [AddrFlatW-1:0]   addr_q;
  logic [MaxCh-1:0]       mask_q;
  logic                   sram_rd_q;
  logic [SramAddrW-1:0]   sram_a_q;
  logic signed [AccW-1:0] sample_out_q;
  logic                   sample_valid_q;
  logic                   data_vld_q;
  logic [ChIdxW-1:0]      data_ch_q;

  logic [EnvW-1:0]        env_arr  [MaxCh];
  logic [WaveAddrW-1:0]   addr_arr [MaxCh];
  logic [ChIdxW-1:0]      next_ch;
  logic                   last_ch;
  logic                   start_acc;
  logic signed [AccW-1:0] acc_next;

  // Snapshots are padded to MaxCh channels so any 3-bit index stays in range.
  always_comb begin
    for (int i = 0; i < MaxCh; i++) begin
      env_arr[i]  = env_q[EnvW*i +: EnvW];
      addr_arr[i] = addr_q[WaveAddrW*i +: WaveAddrW];
    end
  end

  assign next_ch   = ch_q + ChIdxW'(1);
  assign last_ch   = (ch_q == ChIdxW'(NUM_CH - 1));
  assign start_acc = start && (state_q == StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      ch_q           <= '0;
      env_q          <= '0;
      addr_q         <= '0;
      mask_q         <= '0;
      sram_rd_q      <= 1'b0;
      sram_a_q       <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFetch;
            ch_q      <= '0;
            env_q     <= EnvFlatW'(envelope_flat);
            addr_q    <= AddrFlatW'(wave_addr_flat);
            mask_q    <= MaxCh'(channel_mask);
            sram_rd_q <= 1'b1;
            sram_a_q  <= {ChIdxW'(0), wave_addr_flat[WaveAddrW-1:0]};
          end
        end
        StFetch: begin
          // ch_q is the channel whose read is on the bus this cycle.
          if (last_ch) begin
            state_q   <= StDrain;
            sram_rd_q <= 1'b0;
            sram_a_q  <= '0;
          end else begin
            ch_q     <= next_ch;
            sram_a_q <= {next_ch, addr_arr[next_ch]};
          end
        end
        StDrain: begin
          // Last channel's data is being accumulated now; publish the total.
          state_q        <= StDone;
          sample_out_q   <= acc_next;
          sample_valid_q <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Tracks which channel's data sram_q carries (one cycle behind the read).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_vld_q <= 1'b0;
      data_ch_q  <= '0;
    end else begin
      data_vld_q <= sram_rd_q;
      data_ch_q  <= sram_a_q[SramAddrW-1 -: ChIdxW];
    end
  end

  wts_mix_mac u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (start_acc),
    .term_vld_i (data_vld_q),
    .wave_i     (sram_q),
    .envelope_i (env_arr[data_ch_q]),
    .mask_i     (mask_q[data_ch_q]),
    .acc_next_o (acc_next)
  );

  assign busy         = (state_q != StIdle);
  assign overrun      = start && (state_q != StIdle);
  assign sram_rd      = sram_rd_q;
  assign sram_a       = sram_a_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_wts_channel_mixer.sv
module tb_wts_channel_mixer;

  localparam int N = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [8*N-1:0]     envelope_flat;
  logic [7*N-1:0]     wave_addr_flat;
  logic [N-1:0]       channel_mask;
  logic               sram_rd;
  logic [9:0]         sram_a;
  logic [7:0]         sram_q;
  logic               busy;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [1024];

  wts_channel_mixer #(.NUM_CH(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .envelope_flat  (envelope_flat),
    .wave_addr_flat (wave_addr_flat),
    .channel_mask   (channel_mask),
    .sram_rd        (sram_rd),
    .sram_a         (sram_a),
    .sram_q         (sram_q),
    .busy           (busy),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Wave SRAM: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (sram_rd) sram_q <= mem[sram_a];
    else         sram_q <= 8'hA5;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference mix: sum over unmasked channels of floor(wave * env / 16).
  function automatic int mix(input logic [8*N-1:0] env, input logic [7*N-1:0] addr,
                             input logic [N-1:0] mask);
    int s = 0;
    for (int n = 0; n < N; n++) begin
      if (mask[n]) begin
        int w = int'(mem[n * 128 + int'(addr[7*n +: 7])]);
        int e = int'(env[8*n +: 8]);
        if (w >= 128) w -= 256;
        s += (w * e) >>> 4;
      end
    end
    return s;
  endfunction

  // Timeline model: k = cycles since the cycle in which start was accepted.
  int             m_k = -1;
  int             m_exp = 0;
  int             m_out = 0;
  logic [7*N-1:0] m_addr = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_k   = -1;
      m_out = 0;
    end else if (m_k == -1) begin
      if (start) begin
        m_k    = 1;
        m_addr = wave_addr_flat;
        m_exp  = mix(envelope_flat, wave_addr_flat, channel_mask);
      end
    end else begin
      m_k++;
      if (m_k == N + 3) m_k = -1;
    end
    if (m_k == N + 2) m_out = m_exp;
  end

  always @(negedge clk) begin
    int e_busy, e_rd, e_a, e_vld, e_ovr, e_out;
    if (reset) begin
      e_busy = 0; e_rd = 0; e_a = 0; e_vld = 0; e_ovr = 0; e_out = 0;
    end else begin
      e_busy = (m_k >= 1) ? 1 : 0;
      e_rd   = (m_k >= 1 && m_k <= N) ? 1 : 0;
      e_a    = e_rd ? ((m_k - 1) * 128 + int'(m_addr[7*(m_k-1) +: 7])) : 0;
      e_vld  = (m_k == N + 2) ? 1 : 0;
      e_ovr  = (start && e_busy != 0) ? 1 : 0;
      e_out  = m_out;
    end
    chk("busy", int'(busy), e_busy);
    chk("sram_rd", int'(sram_rd), e_rd);
    chk("sram_a", int'(sram_a), e_a);
    chk("sample_valid", int'(sample_valid), e_vld);
    chk("overrun", int'(overrun), e_ovr);
    chk("sample_out", int'(sample_out), e_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for sample_valid; lat=-1 on timeout.
  task automatic wait_valid(input int t, output int lat, output int val);
    lat = -1;
    val = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        lat = cyc - t;
        val = int'(sample_out);
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  initial begin
    int t, lat, val, nv;
    int exp_a [5];
    reset = 1'b1;
    start = 1'b0;
    envelope_flat = '0;
    wave_addr_flat = '0;
    channel_mask = '0;
    fill_mem(8'h7F);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sram_rd", int'(sram_rd), 0);
    reset = 1'b0;
    tick();

    // Full-scale positive
    envelope_flat = {N{8'hFF}};
    wave_addr_flat = {7'h12, 7'h34, 7'h56, 7'h78 >> 1, 7'h01};
    channel_mask = 5'h1F;
    pulse_start(t);
    wait_valid(t, lat, val);
    chk("pos_latency", lat, 7);
    chk("pos_value", val, 10120);

    // Full-scale negative
    fill_mem(8'h80);
    pulse_start(t);
    wait_valid(t, lat, val);
    chk("neg_latency", lat, 7);
    chk("neg_value", val, -10200);

    // Masked, address sequence
    fill_mem(8'h40);
    envelope_flat = {N{8'h10}};
    wave_addr_flat = {7'h47, 7'h36, 7'h25, 7'h14, 7'h03};
    channel_mask = 5'h05;
    exp_a = '{10'h003, 10'h094, 10'h125, 10'h1B6, 10'h247};
    pulse_start(t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sram_a_seq", int'(sram_a), exp_a[i]);
      tick();
    end
    wait_valid(t, lat, val);
    chk("mask_value", val, 128);

    // Varied memory content, model-only expectation
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 255);
    envelope_flat = {8'h9C, 8'h01, 8'hFF, 8'h3A, 8'h80};
    channel_mask = 5'h1B;
    pulse_start(t);
    wait_valid(t, lat, val);
    chk("varied_latency", lat, 7);

    // Overrun: second start at T+3
    fill_mem(8'h7F);
    envelope_flat = {N{8'hFF}};
    channel_mask = 5'h1F;
    pulse_start(t);
    tick();
    tick();
    start = 1'b1;
    @(negedge clk);
    chk("overrun_pulse", int'(overrun), 1);
    tick();
    start = 1'b0;
    nv = 0;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        nv++;
        lat = cyc - t;
      end
      tick();
    end
    chk("overrun_valid_count", nv, 1);
    chk("overrun_valid_cycle", lat, 7);

    // Reset at T+4 aborts the pass
    pulse_start(t);
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample_out", int'(sample_out), 0);
    tick();
    tick();
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sample_valid) nv++;
      tick();
    end
    chk("abort_no_valid", nv, 0);
    pulse_start(t);
    wait_valid(t, lat, val);
    chk("after_abort_latency", lat, 7);
    chk("after_abort_value", val, 10120);

    // Envelope change at T+2 must not affect the pass
    pulse_start(t);
    tick();
    envelope_flat = {N{8'h01}};
    wait_valid(t, lat, val);
    chk("snapshot_value", val, 10120);

    // Start coincident with reset: no pass
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("start_in_reset_busy", int'(busy), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wts_channel_mixer.md
WTS_CHANNEL_MIXER -- requirements
Module: wts_channel_mixer

Interface
REQ-001 Parameter NUM_CH, default 5, number of channel parts mixed (1..8).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse requesting one mix pass.
REQ-005 envelope_flat  input  8*NUM_CH  channel envelopes (noise-gated), channel n at [8n+7:8n], unsigned.
REQ-006 wave_addr_flat  input  7*NUM_CH  channel wave addresses, channel n at [7n+6:7n].
REQ-007 channel_mask  input  NUM_CH  1 = channel n contributes, 0 = muted.
REQ-008 sram_rd  output  1  wave SRAM read strobe.
REQ-009 sram_a  output  10  wave SRAM address {channel[2:0], wave_addr[6:0]}.
REQ-010 sram_q  input  8  wave SRAM data, two's complement, valid the cycle after sram_rd.
REQ-011 busy  output  1  mix pass in progress.
REQ-012 sample_out  output  16  signed mixed sample, held between passes.
REQ-013 sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-014 overrun  output  1  one-cycle pulse when start is dropped.

Function
REQ-015 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start, FETCH->DRAIN after channel NUM_CH-1 issued, DRAIN->DONE after 1 cycle, DONE->IDLE after 1 cycle.
REQ-016 On start accepted in IDLE at cycle T, envelope_flat, wave_addr_flat and channel_mask SHALL be snapshotted; later input changes do not affect the pass.
REQ-017 Cycles T+1..T+NUM_CH (FETCH): sram_rd=1, sram_a={n, snapshot wave_addr n} for n=0..NUM_CH-1 in order; sram_rd=0 and sram_a=0 otherwise.
REQ-018 Cycles T+2..T+NUM_CH+1: term = (signed sram_q * {1'b0, snapshot envelope n}) arithmetic-shifted right 4 (17-bit product, 13-bit term); term forced to 0 if mask bit n is 0.
REQ-019 Accumulator is 16-bit signed, cleared when start is accepted, adds each term; worst case |sum| <= 8*2040 so no overflow or saturation occurs.
REQ-020 Cycle T+NUM_CH+2 (DONE): sample_out <= accumulator, sample_valid=1 for exactly that cycle.
REQ-021 busy=1 in FETCH, DRAIN and DONE; 0 in IDLE; pass latency start->sample_valid is NUM_CH+2 cycles.
REQ-022 start while busy=1 (including the DONE cycle) SHALL be ignored and overrun pulses 1 in that same cycle; the pass in progress is unaffected.
REQ-023 start coincident with reset: reset wins, no pass begins.

Reset
REQ-024 reset asserted: state IDLE, busy=0, sram_rd=0, sram_a=0, sample_out=0, sample_valid=0, overrun=0, accumulator and snapshots 0.
REQ-025 reset mid-pass aborts immediately; no sample_valid is produced for the aborted pass and sample_out reads 0.

Structure
REQ-026 Shared package wts_pkg SHALL hold FSM state encoding, SRAM address width (10), wave data width (8), term shift (4).
REQ-027 One sub-module wts_mix_mac SHALL implement the signed-by-unsigned multiply, shift, mask and accumulate; FSM and addressing stay in the top.

Verification
REQ-028 NUM_CH=5, all sram_q=0x7F, envelopes 0xFF, mask 0x1F, start -> sample_valid 7 cycles later, sample_out=10120.
REQ-029 All sram_q=0x80, envelopes 0xFF, mask 0x1F -> sample_out=-10200 (0xD828).
REQ-030 sram_q=0x40 all channels, envelopes 0x10, mask 0x05 -> sample_out=128; sram_a sequence 0x000+addr0 .. 0x200+addr4 observed.
REQ-031 start pulsed at T and T+3 -> second start produces overrun=1 at T+3, exactly one sample_valid at T+7.
REQ-032 reset asserted at T+4 of a pass -> no sample_valid, sample_out=0, busy=0; a fresh start afterwards completes normally.
REQ-033 envelope_flat changed at T+2 -> sample_out matches values present at T.
